// File: rtl/fpga_link_pkg.sv
// Shared definitions for the FPGA-to-FPGA serial link (transmitter and receiver).
package fpga_link_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        SEND         = 2'd1,
        FINISH       = 2'd2,
        WAIT_RELEASE = 2'd3
    } link_state_e;

    localparam int LINK_WIDTH       = 8;
    localparam int LINK_ACK_TIMEOUT = 1024;
    localparam int LINK_SYNC_STAGES = 2;

    // Bits needed to hold 0..max_value; a zero maximum still gets one bit.
    function automatic int counter_width(input int max_value);
        return (max_value > 0) ? $clog2(max_value + 1) : 1;
    endfunction

endpackage

// File: rtl/fpga_transmitter_if.sv
// Local-system and link-side signals of the transmitter, bundled for connection.
interface fpga_transmitter_if import fpga_link_pkg::*; #(
    parameter int WIDTH = LINK_WIDTH
);
    logic [WIDTH-1:0] data_in;
    logic             load;
    logic             ready;
    logic             data;
    logic             send;
    logic             finish;
    logic             acknowledge;
    logic             error;

    modport master (
        input  data_in, load, acknowledge,
        output ready, data, send, finish, error
    );

    modport slave (
        output data_in, load, acknowledge,
        input  ready, data, send, finish, error
    );
endinterface

// File: rtl/piso_register.sv
// Parallel-load, shift-left register; the MSB is the next bit to go on the wire.
module piso_register #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] load_value,
    output logic             msb
);
    logic [WIDTH-1:0] shift_r;

    // Load has priority over shift; otherwise hold the contents.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shift_r <= '0;
        end else if (load) begin
            shift_r <= load_value;
        end else if (shift) begin
            shift_r <= shift_r << 1;
        end else begin
            shift_r <= shift_r;
        end
    end

    assign msb = shift_r[WIDTH-1];
endmodule

// File: rtl/fpga_transmitter.sv
// Serialising source for the FPGA link: byte in, MSB-first bits out, four-phase ack.
module fpga_transmitter import fpga_link_pkg::*; #(
    parameter int WIDTH       = LINK_WIDTH,
    parameter int ACK_TIMEOUT = LINK_ACK_TIMEOUT,
    parameter int SYNC_STAGES = LINK_SYNC_STAGES
) (
    input  logic              clock,
    input  logic              reset,
    fpga_transmitter_if.master link
);
    localparam int                CNT_W      = counter_width(WIDTH);
    localparam int                TO_W       = counter_width(ACK_TIMEOUT);
    localparam logic [CNT_W-1:0]  LAST_BIT   = CNT_W'(WIDTH - 1);
    localparam logic [TO_W-1:0]   TO_LAST    = TO_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
    localparam logic [TO_W-1:0]   TO_MAX     = {TO_W{1'b1}};
    localparam bit                TO_ENABLED = (ACK_TIMEOUT > 0);

    link_state_e            state_r;
    link_state_e            state_next_s;
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   ack_sync_s;
    logic [CNT_W-1:0]       bit_cnt_r;
    logic [TO_W-1:0]        to_cnt_r;
    logic                   accept_s;
    logic                   timeout_s;
    logic                   waiting_s;
    logic                   piso_msb_s;
    logic [WIDTH-1:0]       piso_load_s;

    logic ready_r, data_r, send_r, finish_r, error_r;
    logic ready_next_s, data_next_s, send_next_s, finish_next_s, error_next_s;

    // Bring the far-end acknowledge into the local clock domain.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], link.acknowledge};
        end
    end

    assign ack_sync_s = sync_r[SYNC_STAGES-1];
    assign accept_s   = (state_r == IDLE) && ready_r && link.load;
    assign waiting_s  = (state_r == FINISH) || (state_r == WAIT_RELEASE);
    assign timeout_s  = TO_ENABLED && waiting_s && (to_cnt_r == TO_LAST);
    // Pre-shifted so the register MSB is always the bit after the one on the wire.
    assign piso_load_s = link.data_in << 1;

    piso_register #(.WIDTH(WIDTH)) u_piso (
        .clock      (clock),
        .reset      (reset),
        .load       (accept_s),
        .shift      (state_r == SEND),
        .load_value (piso_load_s),
        .msb        (piso_msb_s)
    );

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; a timeout wins over a coincident acknowledge change.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE:         state_next_s = accept_s ? SEND : IDLE;
            SEND:         state_next_s = (bit_cnt_r == LAST_BIT) ? FINISH : SEND;
            FINISH: begin
                if (timeout_s)       state_next_s = IDLE;
                else if (ack_sync_s) state_next_s = WAIT_RELEASE;
                else                 state_next_s = FINISH;
            end
            WAIT_RELEASE: begin
                if (timeout_s)        state_next_s = IDLE;
                else if (!ack_sync_s) state_next_s = IDLE;
                else                  state_next_s = WAIT_RELEASE;
            end
            default:      state_next_s = IDLE;
        endcase
    end

    // Bit and timeout counters: cleared on every state entry; timeout saturates.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bit_cnt_r <= '0;
            to_cnt_r  <= '0;
        end else if (state_next_s != state_r) begin
            bit_cnt_r <= '0;
            to_cnt_r  <= '0;
        end else begin
            bit_cnt_r <= (state_r == SEND) ? bit_cnt_r + CNT_W'(1) : bit_cnt_r;
            to_cnt_r  <= (waiting_s && (to_cnt_r != TO_MAX)) ? to_cnt_r + TO_W'(1) : to_cnt_r;
        end
    end

    // Output values for the coming cycle, decoded from the next state.
    always_comb begin
        ready_next_s  = 1'b0;
        send_next_s   = 1'b0;
        finish_next_s = 1'b0;
        data_next_s   = 1'b0;
        error_next_s  = timeout_s;
        case (state_next_s)
            IDLE:         ready_next_s  = 1'b1;
            SEND: begin
                send_next_s = 1'b1;
                data_next_s = accept_s ? link.data_in[WIDTH-1] : piso_msb_s;
            end
            FINISH:       finish_next_s = 1'b1;
            WAIT_RELEASE: finish_next_s = 1'b0;
            default:      ready_next_s  = 1'b1;
        endcase
    end

    // Output registers, so nothing combinational reaches the pins.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ready_r  <= 1'b1;
            data_r   <= 1'b0;
            send_r   <= 1'b0;
            finish_r <= 1'b0;
            error_r  <= 1'b0;
        end else begin
            ready_r  <= ready_next_s;
            data_r   <= data_next_s;
            send_r   <= send_next_s;
            finish_r <= finish_next_s;
            error_r  <= error_next_s;
        end
    end

    assign link.ready  = ready_r;
    assign link.data   = data_r;
    assign link.send   = send_r;
    assign link.finish = finish_r;
    assign link.error  = error_r;
endmodule

// File: tb/tb_fpga_transmitter.sv
// Self-checking bench for fpga_transmitter: vector table, random scoreboard, corner sequences.
module tb_fpga_transmitter;
    localparam int W    = 8;
    localparam int SYNC = 2;
    localparam int LAT  = SYNC + 1;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clock = ~clock;

    fpga_transmitter_if #(.WIDTH(W)) if_a ();
    fpga_transmitter_if #(.WIDTH(W)) if_t ();
    fpga_transmitter_if #(.WIDTH(W)) if_z ();

    fpga_transmitter #(.WIDTH(W), .ACK_TIMEOUT(1024), .SYNC_STAGES(SYNC)) dut_a (
        .clock(clock), .reset(reset), .link(if_a));
    fpga_transmitter #(.WIDTH(W), .ACK_TIMEOUT(16), .SYNC_STAGES(SYNC)) dut_t (
        .clock(clock), .reset(reset), .link(if_t));
    fpga_transmitter #(.WIDTH(W), .ACK_TIMEOUT(0), .SYNC_STAGES(SYNC)) dut_z (
        .clock(clock), .reset(reset), .link(if_z));

    typedef struct {
        logic [7:0] byte_v;
        int         ack_delay;
        int         rel_delay;
        bit         poke;
        logic [7:0] exp_bits;   // serial line read MSB first, packed left to right
        int         exp_fin_lat;
        int         exp_rdy_lat;
    } vec_t;

    vec_t       vecs[4];
    logic [7:0] sb_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Samples the 8 SEND cycles starting at the current negedge; ends at negedge of A+W+1.
    task automatic capture_bits(input bit poke, output logic [7:0] bits, output int send_cycles);
        bits = '0;
        send_cycles = 0;
        for (int k = 0; k < W; k++) begin
            if (if_a.send) send_cycles++;
            bits = {bits[6:0], if_a.data};
            if (poke && k == 2) begin
                if_a.load = 1'b1;
                if_a.data_in = 8'h3C;
            end else if (poke && k == 3) begin
                if_a.load = 1'b0;
            end
            @(negedge clock);
        end
    endtask

    // Four-phase handshake from FINISH; ends at the negedge where ready is seen high.
    task automatic handshake(input int ack_delay, input int rel_delay,
                             output int fin_lat, output int rdy_lat, output int err_seen);
        err_seen = 0;
        repeat (ack_delay) begin
            if (if_a.error) err_seen++;
            @(negedge clock);
        end
        if_a.acknowledge = 1'b1;
        fin_lat = 0;
        while (if_a.finish && fin_lat < 20) begin
            @(negedge clock);
            fin_lat++;
            if (if_a.error) err_seen++;
        end
        repeat (rel_delay) @(negedge clock);
        if_a.acknowledge = 1'b0;
        rdy_lat = 0;
        while (!if_a.ready && rdy_lat < 20) begin
            @(negedge clock);
            rdy_lat++;
            if (if_a.error) err_seen++;
        end
    endtask

    task automatic run_transfer(input string tag, input logic [7:0] b, input int ack_delay,
                                input int rel_delay, input bit poke,
                                output logic [7:0] bits, output int fin_lat, output int rdy_lat);
        int sc;
        int es;
        if_a.data_in = b;
        if_a.load = 1'b1;
        @(posedge clock);
        @(negedge clock);
        if_a.load = 1'b0;
        if_a.data_in = 8'($urandom);
        capture_bits(poke, bits, sc);
        check({tag, "_send_cycles"}, 32'(sc), 32'(W));
        check({tag, "_finish_hi"}, {31'd0, if_a.finish}, 32'd1);
        check({tag, "_send_lo"}, {31'd0, if_a.send}, 32'd0);
        handshake(ack_delay, rel_delay, fin_lat, rdy_lat, es);
        check({tag, "_no_error"}, 32'(es), 32'd0);
    endtask

    initial begin
        logic [7:0] bits;
        logic [7:0] b;
        int fl, rl, n, bad_f, bad_e, sc, es;

        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [7:0] bits;
        logic [7:0] b;
        logic [7:0] exp_b;
        int fl, rl, n, bad_f, bad_e, sc, es;

        if_a.data_in = '0; if_a.load = 1'b0; if_a.acknowledge = 1'b0;
        if_t.data_in = '0; if_t.load = 1'b0; if_t.acknowledge = 1'b0;
        if_z.data_in = '0; if_z.load = 1'b0; if_z.acknowledge = 1'b0;

        vecs[0] = '{8'hA5, 3, 3, 1'b0, 8'b1010_0101, LAT, LAT};
        vecs[1] = '{8'h80, 0, 0, 1'b0, 8'b1000_0000, LAT, LAT};
        vecs[2] = '{8'h01, 5, 1, 1'b1, 8'b0000_0001, LAT, LAT};
        vecs[3] = '{8'h96, 1, 4, 1'b1, 8'b1001_0110, LAT, LAT};

        // Reset state, held and after release.
        repeat (3) @(negedge clock);
        check("rst_ready", {31'd0, if_a.ready}, 32'd1);
        check("rst_send", {31'd0, if_a.send}, 32'd0);
        reset = 1'b1;
        @(negedge clock);
        check("rel_ready", {31'd0, if_a.ready}, 32'd1);
        check("rel_outs", {28'd0, if_a.send, if_a.finish, if_a.data, if_a.error}, 32'd0);

        // Vector table.
        for (int i = 0; i < 4; i++) begin
            run_transfer($sformatf("vec%0d", i), vecs[i].byte_v, vecs[i].ack_delay,
                         vecs[i].rel_delay, vecs[i].poke, bits, fl, rl);
            check($sformatf("vec%0d_bits", i), {24'd0, bits}, {24'd0, vecs[i].exp_bits});
            check($sformatf("vec%0d_fin_lat", i), 32'(fl), 32'(vecs[i].exp_fin_lat));
            check($sformatf("vec%0d_rdy_lat", i), 32'(rl), 32'(vecs[i].exp_rdy_lat));
        end

        // Random transfers against a byte scoreboard.
        for (int i = 0; i < 16; i++) begin
            b = 8'($urandom);
            sb_q.push_back(b);
            run_transfer("rnd", b, int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
                         1'($urandom), bits, fl, rl);
            exp_b = sb_q.pop_front();
            check("rnd_bits", {24'd0, bits}, {24'd0, exp_b});
            check("rnd_fin_lat", 32'(fl), 32'(LAT));
            check("rnd_rdy_lat", 32'(rl), 32'(LAT));
        end

        // Immediate loopback: ready returns W + 2*(SYNC+1) + 1 edges after accept.
        if_a.data_in = 8'($urandom);
        if_a.load = 1'b1;
        @(posedge clock);
        @(negedge clock);
        if_a.load = 1'b0;
        n = 1;
        while (!if_a.ready && n < 40) begin
            if_a.acknowledge = if_a.finish;
            @(negedge clock);
            n++;
        end
        check("loopback_period", 32'(n), 32'(W + 2 * LAT + 1));

        // Back-to-back 0x00 then 0xFF with load held.
        if_a.data_in = 8'h00;
        if_a.load = 1'b1;
        @(posedge clock);
        @(negedge clock);
        if_a.data_in = 8'hFF;
        capture_bits(1'b0, bits, sc);
        check("b2b_first_bits", {24'd0, bits}, 32'h00);
        handshake(0, 0, fl, rl, es);
        check("b2b_first_rdy", {31'd0, if_a.ready}, 32'd1);
        @(posedge clock);
        @(negedge clock);
        check("b2b_no_gap_send", {31'd0, if_a.send}, 32'd1);
        check("b2b_ready_low", {31'd0, if_a.ready}, 32'd0);
        if_a.load = 1'b0;
        capture_bits(1'b0, bits, sc);
        check("b2b_second_bits", {24'd0, bits}, 32'hFF);
        handshake(0, 0, fl, rl, es);
        check("b2b_second_rdy_lat", 32'(rl), 32'(LAT));

        // Reset asserted mid-SEND: outputs drop before the next edge.
        if_a.data_in = 8'hFF;
        if_a.load = 1'b1;
        @(posedge clock);
        @(negedge clock);
        if_a.load = 1'b0;
        repeat (2) @(negedge clock);
        check("mid_send_active", {31'd0, if_a.send}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("async_rst_ready", {31'd0, if_a.ready}, 32'd1);
        check("async_rst_outs", {28'd0, if_a.send, if_a.finish, if_a.data, if_a.error}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("post_rst_idle", {29'd0, if_a.ready, if_a.send, if_a.error}, 32'b100);

        // Timeout of 16 with acknowledge never returned.
        if_t.data_in = 8'($urandom);
        if_t.load = 1'b1;
        @(posedge clock);
        @(negedge clock);
        if_t.load = 1'b0;
        n = 0;
        while (!if_t.finish && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("to_finish_rise", 32'(n), 32'(W));
        n = 0;
        while (!if_t.error && n < 40) begin
            @(negedge clock);
            n++;
        end
        check("to_error_delay", 32'(n), 32'd16);
        check("to_finish_drop", {31'd0, if_t.finish}, 32'd0);
        @(negedge clock);
        check("to_error_single", {31'd0, if_t.error}, 32'd0);
        check("to_ready", {31'd0, if_t.ready}, 32'd1);

        // Timeout disabled: finish holds, error never fires.
        if_z.data_in = 8'($urandom);
        if_z.load = 1'b1;
        @(posedge clock);
        @(negedge clock);
        if_z.load = 1'b0;
        repeat (W) @(negedge clock);
        bad_f = 0;
        bad_e = 0;
        repeat (5000) begin
            if (!if_z.finish) bad_f++;
            if (if_z.error) bad_e++;
            @(negedge clock);
        end
        check("nto_finish_held", 32'(bad_f), 32'd0);
        check("nto_no_error", 32'(bad_e), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fpga_transmitter.md
# fpga_transmitter

Serialising source for the FPGA-to-FPGA link. Accepts a parallel byte from the local system, shifts it onto the serial `data` line framed by `send` and `finish`, then waits for the far-end receiver's `acknowledge` in a four-phase handshake. It sits directly upstream of `fpga_receiver` and drives that block's `data`, `send` and `finish` inputs. It includes an acknowledge timeout so that a dead link cannot hang the local system.

## Interface
- `WIDTH`, default 8: payload bits per transfer.
- `ACK_TIMEOUT`, default 1024: maximum cycles spent waiting on `acknowledge` per phase; 0 disables the timeout.
- `SYNC_STAGES`, default 2: flop stages on the `acknowledge` input (minimum 2).

Ports:
- `clock`, input, 1: system clock; all logic is rising-edge.
- `reset`, input, 1: asynchronous, active-low reset (0 = reset).
- `data_in`, input, WIDTH: byte to transmit; sampled on accept.
- `load`, input, 1: local system requests a transfer.
- `ready`, output, 1: idle, able to accept `load`.
- `data`, output, 1: serial line, MSB first.
- `send`, output, 1: high while `data` carries a valid bit.
- `finish`, output, 1: high after the last bit until acknowledged.
- `acknowledge`, input, 1: from the receiver; asynchronous to the local logic, so it is synchronised before use.
- `error`, output, 1: one-cycle pulse on acknowledge timeout.

## Operation
- States: IDLE, SEND, FINISH, WAIT_RELEASE.
- Reset values: `ready`=1, `data`=0, `send`=0, `finish`=0, `error`=0. State goes to IDLE, the bit counter to 0, the timeout counter to 0 and the synchronizer to 0.
- IDLE:
  - A cycle with `load`=1 and `ready`=1 is an accept: `data_in` is latched and the block moves to SEND.
  - `load` while not ready is ignored. It is neither queued nor an error.
- SEND:
  - Lasts exactly WIDTH cycles with `send`=1.
  - `data` = latched[WIDTH-1-k] in the k-th SEND cycle (k = 0..WIDTH-1).
  - After the last bit the block moves to FINISH.
- FINISH:
  - `send`=0, `finish`=1, `data`=0.
  - Synchronised ack = 1 → WAIT_RELEASE.
- WAIT_RELEASE:
  - `finish`=0.
  - Synchronised ack = 0 → IDLE, and `ready` rises.
- Timeout:
  - A counter clears on every state entry and increments in FINISH and WAIT_RELEASE.
  - When it reaches ACK_TIMEOUT (and ACK_TIMEOUT ≠ 0), `error` pulses for one cycle, `finish` drops and the block enters IDLE.
  - The counter saturates and never wraps.
- Ack already high on entry to FINISH (stale level from a previous transfer): the block still goes to WAIT_RELEASE and then waits for the low level. This is legal; the receiver owns correctness.
- Reset mid-transfer: all outputs return to their reset values immediately. The partially sent byte is discarded, with no `error` pulse.

## Timing
- Cycle A = accept edge.
- Cycles A+1 .. A+WIDTH: `send`=1, one bit per cycle.
- Cycle A+WIDTH+1: `finish`=1 (send-to-finish has no gap).
- `acknowledge` rising at the input → `finish` falls SYNC_STAGES+1 cycles later.
- `acknowledge` falling → `ready`=1 SYNC_STAGES+1 cycles later. The next accept is possible that same cycle.
- Minimum transfer period with an immediate ack: WIDTH + 2·(SYNC_STAGES+1) + 1 cycles.
- Outputs are registered; there is no combinational path from input to output.

## Structure
- The shared package `fpga_link_pkg` holds:
  - the state enum (IDLE, SEND, FINISH, WAIT_RELEASE);
  - the default link width (8);
  - the default timeout and synchronizer depth.
- The receiver side reuses the same package.
- One sub-module is natural: `piso_register`, a WIDTH-bit parallel-load, shift-left register exposing its MSB. It is the transmit counterpart of the receiver's shift register.
- The synchronizer, the bit counter (clog2(WIDTH+1) bits) and the timeout counter stay inline.

## Test plan
- Reset, then release: `ready`=1, `send`=`finish`=`data`=`error`=0. Assert `reset`=0 mid-SEND: outputs return to reset values asynchronously, before the next edge.
- `load` with `data_in`=0xA5 and ack looped back after 3 cycles:
  - `data` reads 1,0,1,0,0,1,0,1 on cycles A+1..A+8 with `send`=1;
  - `finish`=1 at A+9;
  - `finish` drops 3 cycles after ack rises;
  - `ready` returns 3 cycles after ack falls.
- Back-to-back transfers 0x00 then 0xFF with `load` held high: the second accept occurs on the first cycle `ready`=1. Bits are 0×8 then 1×8. No extra gap.
- `load` pulsed during SEND with `data_in`=0x3C: ignored; the in-flight byte is unchanged.
- ACK_TIMEOUT=16, ack never asserted:
  - `error` pulses once, exactly 16 cycles after `finish` rises;
  - `finish` drops;
  - `ready`=1 the next cycle.
- ACK_TIMEOUT=0 with ack withheld for 5000 cycles: `finish` stays high and `error` never asserts.
